// File: rtl/miriscv_int_pkg.sv
// miriscv_int_pkg: shared state encoding and constants for the miriscv interrupt controller
package miriscv_int_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, PENDING, CLEAR} state_t;
  localparam int MCAUSE_INT_BIT = 31;
  localparam int N_IRQ_DEFAULT = 32;
endpackage

// File: rtl/miriscv_int_prio_enc.sv
// miriscv_int_prio_enc: lowest-set-bit encoder used by the fixed-priority build
module miriscv_int_prio_enc #(
  parameter int N_IRQ = 32
) (
  input  logic [N_IRQ-1:0]         i_req,
  output logic [$clog2(N_IRQ)-1:0] o_idx,
  output logic                     o_valid
);
  localparam int IDX_W = $clog2(N_IRQ);
  always_comb begin
    o_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (i_req[i]) o_idx = IDX_W'(i);
  end
  assign o_valid = |i_req;
endmodule

// File: rtl/miriscv_int_ctrl.sv
// miriscv_int_ctrl: masked round-robin interrupt responder; MIRISCV_INT_PRIO_EN selects fixed priority
module miriscv_int_ctrl
  import miriscv_int_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] int_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             int_fin_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] int_rst_o
);
  localparam int IDX_W = $clog2(N_IRQ);
  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [N_IRQ-1:0] w_masked;
  assign w_masked = int_req_i & mie_i;
`ifdef MIRISCV_INT_PRIO_EN
  logic [IDX_W-1:0] w_enc_idx;
  logic             w_enc_vld;
  miriscv_int_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .i_req   (w_masked),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_vld)
  );
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
`ifdef MIRISCV_INT_PRIO_EN
      IDLE: if (w_enc_vld) begin
        w_idx_nxt   = w_enc_idx;
        w_state_nxt = PENDING;
      end
`else
      IDLE: if (|w_masked) w_state_nxt = SCAN;
`endif
      SCAN: if (w_masked[r_cnt]) begin
        w_idx_nxt   = r_cnt;
        w_state_nxt = PENDING;
      end else if (~|w_masked) w_state_nxt = IDLE;
      else w_cnt_nxt = r_cnt + 1'b1;
      PENDING: if (int_fin_i) w_state_nxt = CLEAR;
      CLEAR: begin
`ifndef MIRISCV_INT_PRIO_EN
        w_cnt_nxt   = r_idx + 1'b1;
`endif
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end
  // outputs decode only registered state, so they cannot glitch on request edges
  assign int_o     = r_state == PENDING;
  assign mcause_o  = int_o ? ((32'd1 << MCAUSE_INT_BIT) | 32'(r_idx)) : '0;
  assign int_rst_o = (r_state == CLEAR) ? (N_IRQ'(1) << r_idx) : '0;
endmodule
